// File: rtl/ov_cam_emulator_if.sv
// OV7670-style camera pin bundle plus the emulator's run control and frame status.
// Ports: enable/pattern_sel (control into emulator); vsync/href/pixdata (camera bus);
//        frame_cnt/frame_done/busy (status). master = emulator side, slave = receiver/bench side.
interface ov_cam_emulator_if;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic        vsync;
  logic        href;
  logic [7:0]  pixdata;
  logic [15:0] frame_cnt;
  logic        frame_done;
  logic        busy;

  modport master (
    input  enable, pattern_sel,
    output vsync, href, pixdata, frame_cnt, frame_done, busy
  );

  modport slave (
    output enable, pattern_sel,
    input  vsync, href, pixdata, frame_cnt, frame_done, busy
  );
endinterface

// File: rtl/ov_cam_emulator.sv
// Synthetic OV7670 transmitter: VSYNC/HREF/PIXDATA frames of RGB565 test patterns, MSB byte first.
// Ports: XCLK (byte clock, rising edge), pll_rst (async, active-high), cam (master modport).
// Latency: every pin is registered, one cycle behind the state/hcnt decode; no backpressure.
module ov_cam_emulator #(
  parameter int H_ACTIVE  = 640,
  parameter int H_BLANK   = 288,
  parameter int V_ACTIVE  = 480,
  parameter int VS_LINES  = 3,
  parameter int VBP_LINES = 17,
  parameter int VFP_LINES = 10
) (
  input logic               XCLK,
  input logic               pll_rst,
  ov_cam_emulator_if.master cam
);

  localparam int LINE  = 2 * H_ACTIVE + H_BLANK;
  localparam int BAR_W = H_ACTIVE / 8;

  // Counter widths are fixed (hcnt 12b, line counter 10b); reject parameter sets that overflow them.
  if (LINE > 4096) begin : g_chk_line
    $error("ov_cam_emulator: line length exceeds 12-bit hcnt");
  end
  if (H_ACTIVE < 8 || (H_ACTIVE % 8) != 0) begin : g_chk_hact
    $error("ov_cam_emulator: H_ACTIVE must be a nonzero multiple of 8");
  end
  if (V_ACTIVE < 1 || V_ACTIVE > 1024 || VS_LINES < 1 || VS_LINES > 1024 ||
      VBP_LINES < 1 || VBP_LINES > 1024 || VFP_LINES < 1 || VFP_LINES > 1024) begin : g_chk_lines
    $error("ov_cam_emulator: line counts must be 1..1024");
  end

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBP, S_ACTIVE, S_VFP} state_t;

  state_t      state, state_nxt, succ;
  logic [11:0] hcnt, hcnt_nxt;
  logic [9:0]  lcnt, lcnt_nxt, lim;
  logic [1:0]  pat;
  logic [15:0] frame_cnt_r;
  logic        start, frame_end;
  logic        line_end;

  logic        vsync_r, href_r, frame_done_r, busy_r;
  logic [7:0]  pixdata_r;

  logic [10:0] x;
  logic [2:0]  bar;
  logic [15:0] pix;
  logic [7:0]  pix_byte;
  logic        href_d;

  assign line_end = (hcnt == 12'(LINE - 1));

  // Next state / counters. Each timed state lasts lim+1 whole lines, then hands over to succ
  // with both counters cleared. start marks the edges where pattern_sel is captured.
  always_comb begin
    lim       = '0;
    succ      = S_IDLE;
    state_nxt = state;
    hcnt_nxt  = hcnt;
    lcnt_nxt  = lcnt;
    frame_end = 1'b0;
    start     = 1'b0;

    case (state)
      S_VSYNC:  begin lim = 10'(VS_LINES - 1);  succ = S_VBP;    end
      S_VBP:    begin lim = 10'(VBP_LINES - 1); succ = S_ACTIVE; end
      S_ACTIVE: begin lim = 10'(V_ACTIVE - 1);  succ = S_VFP;    end
      S_VFP:    begin lim = 10'(VFP_LINES - 1); succ = cam.enable ? S_VSYNC : S_IDLE; end
      default:  ;
    endcase

    if (state == S_IDLE) begin
      if (cam.enable) begin
        state_nxt = S_VSYNC;
        start     = 1'b1;
      end
    end else begin
      hcnt_nxt = line_end ? 12'd0 : hcnt + 12'd1;
      if (line_end) begin
        if (lcnt == lim) begin
          lcnt_nxt  = '0;
          state_nxt = succ;
          if (state == S_VFP) begin
            frame_end = 1'b1;
            start     = cam.enable;
          end
        end else begin
          lcnt_nxt = lcnt + 10'd1;
        end
      end
    end
  end

  // Pixel generator: x counts pixels (two bytes each), y is the active line index.
  always_comb begin
    x   = hcnt[11:1];
    bar = 3'(x / 11'(BAR_W));
    pix = 16'h0000;
    case (pat)
      2'd0: begin
        case (bar)
          3'd0:    pix = 16'hFFFF;
          3'd1:    pix = 16'hFFE0;
          3'd2:    pix = 16'h07FF;
          3'd3:    pix = 16'h07E0;
          3'd4:    pix = 16'hF81F;
          3'd5:    pix = 16'hF800;
          3'd6:    pix = 16'h001F;
          default: pix = 16'h0000;
        endcase
      end
      2'd1:    pix = 16'(x) + 16'(lcnt);
      // 32x32 tiles; the frame counter's LSB flips the phase every frame.
      2'd2:    pix = (x[5] ^ lcnt[5] ^ frame_cnt_r[0]) ? 16'hFFFF : 16'h0000;
      default: pix = 16'hF800;
    endcase
    pix_byte = hcnt[0] ? pix[7:0] : pix[15:8];
    href_d   = (state == S_ACTIVE) && (hcnt < 12'(2 * H_ACTIVE));
  end

  always_ff @(posedge XCLK or posedge pll_rst) begin
    if (pll_rst) begin
      state        <= S_IDLE;
      hcnt         <= '0;
      lcnt         <= '0;
      pat          <= '0;
      frame_cnt_r  <= '0;
      vsync_r      <= 1'b0;
      href_r       <= 1'b0;
      pixdata_r    <= '0;
      frame_done_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state        <= state_nxt;
      hcnt         <= hcnt_nxt;
      lcnt         <= lcnt_nxt;
      if (start)     pat         <= cam.pattern_sel;
      if (frame_end) frame_cnt_r <= frame_cnt_r + 16'd1;
      vsync_r      <= (state == S_VSYNC);
      href_r       <= href_d;
      pixdata_r    <= href_d ? pix_byte : 8'h00;
      // Registered like the bus pins, so the pulse lines up with the frame's last output cycle.
      frame_done_r <= frame_end;
      busy_r       <= (state != S_IDLE);
    end
  end

  assign cam.vsync      = vsync_r;
  assign cam.href       = href_r;
  assign cam.pixdata    = pixdata_r;
  assign cam.frame_cnt  = frame_cnt_r;
  assign cam.frame_done = frame_done_r;
  assign cam.busy       = busy_r;

endmodule

// File: tb/tb_ov_cam_emulator.sv
// Bench for ov_cam_emulator: one default-size instance (bar bytes, first HREF delay) and one
// small instance (frame timing, pattern switching, checker phase, mid-frame reset, enable drop).
// Pixel bytes of the small instance are checked against a scoreboard queue filled up front.
module tb_ov_cam_emulator;

  logic XCLK;
  logic rst_d, rst_s;

  ov_cam_emulator_if if_d ();
  ov_cam_emulator_if if_s ();

  ov_cam_emulator dut_d (
    .XCLK    (XCLK),
    .pll_rst (rst_d),
    .cam     (if_d)
  );

  ov_cam_emulator #(
    .H_ACTIVE (16), .H_BLANK (8), .V_ACTIVE (4),
    .VS_LINES (1),  .VBP_LINES (2), .VFP_LINES (1)
  ) dut_s (
    .XCLK    (XCLK),
    .pll_rst (rst_s),
    .cam     (if_s)
  );

  initial XCLK = 1'b0;
  always #5 XCLK = ~XCLK;

  int checks;
  int failures;

  typedef struct { logic [7:0] val; int f; int y; int x; } sb_t;
  typedef struct { int idx; logic [7:0] val; } dsb_t;
  sb_t  sbq[$];
  dsb_t sbd[$];
  sb_t  mon_e;
  logic mon_en;
  int   fd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge XCLK);
    #1;
  endtask

  function automatic logic probe(input int what);
    case (what)
      0:       return if_s.vsync;
      1:       return if_s.href;
      2:       return if_s.frame_done;
      3:       return if_d.vsync;
      4:       return if_d.href;
      5:       return if_s.href && (if_s.frame_cnt == 16'd1);
      6:       return if_s.href && (if_s.frame_cnt == 16'd3);
      7:       return if_s.href && (if_s.frame_cnt == 16'd2);
      default: return 1'b0;
    endcase
  endfunction

  // Bounded wait; an expired budget shows up as a failed check on the probed condition.
  task automatic wait_hi(input string tag, input int what, input int budget, output int cyc);
    cyc = 0;
    while (!probe(what) && cyc < budget) begin
      tick();
      cyc++;
    end
    chk(tag, {31'd0, probe(what)}, 32'd1);
  endtask

  function automatic logic [15:0] model_pix(input int pat, input int x, input int y, input int fc);
    logic [15:0] p;
    p = 16'h0000;
    case (pat)
      0: begin
        case (x / 2)   // small instance: 16 pixels, bars 2 wide
          0: p = 16'hFFFF;
          1: p = 16'hFFE0;
          2: p = 16'h07FF;
          3: p = 16'h07E0;
          4: p = 16'hF81F;
          5: p = 16'hF800;
          6: p = 16'h001F;
          default: p = 16'h0000;
        endcase
      end
      1: p = 16'(x + y);
      2: p = ((((x >> 5) ^ (y >> 5) ^ fc) & 1) != 0) ? 16'hFFFF : 16'h0000;
      default: p = 16'hF800;
    endcase
    return p;
  endfunction

  task automatic push_frame(input int pat, input int fc);
    logic [15:0] p;
    for (int y = 0; y < 4; y++) begin
      for (int x = 0; x < 16; x++) begin
        p = model_pix(pat, x, y, fc);
        sbq.push_back('{val: p[15:8], f: fc, y: y, x: x});
        sbq.push_back('{val: p[7:0],  f: fc, y: y, x: x});
      end
    end
  endtask

  task automatic push_d(input int idx, input logic [7:0] val);
    sbd.push_back('{idx: idx, val: val});
  endtask

  // Scoreboard monitor for the small instance: each HREF byte pops one expected byte.
  always @(posedge XCLK) begin
    #1;
    if (if_s.frame_done) fd_cnt++;
    if (mon_en) begin
      if (if_s.href) begin
        if (sbq.size() == 0) begin
          chk("sb_underflow", sbq.size(), 1);
        end else begin
          mon_e = sbq.pop_front();
          chk($sformatf("pix f%0d y%0d x%0d", mon_e.f, mon_e.y, mon_e.x), if_s.pixdata, mon_e.val);
        end
      end else begin
        chk("pix_blank", if_s.pixdata, 0);
      end
    end
  end

  initial begin
    int   c, c1, c2, n;
    dsb_t de;
    logic vs_seen;

    checks = 0; failures = 0; fd_cnt = 0; mon_en = 1'b0;
    rst_d = 1'b1; rst_s = 1'b1;
    if_d.enable = 1'b0; if_d.pattern_sel = 2'd0;
    if_s.enable = 1'b0; if_s.pattern_sel = 2'd0;
    repeat (3) tick();

    chk("rst_vsync",      if_s.vsync, 0);
    chk("rst_href",       if_s.href, 0);
    chk("rst_pixdata",    if_s.pixdata, 0);
    chk("rst_frame_cnt",  if_s.frame_cnt, 0);
    chk("rst_frame_done", if_s.frame_done, 0);
    chk("rst_busy",       if_s.busy, 0);
    chk("rst_d_busy",     if_d.busy, 0);
    rst_d = 1'b0; rst_s = 1'b0;
    tick(); tick();
    chk("idle_busy",  if_s.busy, 0);
    chk("idle_vsync", if_s.vsync, 0);

    // Colour bars on the full-size instance, frame 0 line 0.
    push_d(0, 8'hFF);   push_d(1, 8'hFF);
    push_d(159, 8'hFF); push_d(160, 8'hFF); push_d(161, 8'hE0);
    push_d(480, 8'h07); push_d(481, 8'hE0);
    push_d(800, 8'hF8); push_d(801, 8'h00);
    push_d(1278, 8'h00); push_d(1279, 8'h00);
    if_d.enable = 1'b1;
    wait_hi("d_vs_rise", 3, 10, c);
    wait_hi("d_href_rise", 4, 40000, c);
    chk("d_href_delay", c, 31360);
    n = 0;
    while (if_d.href && n < 2000) begin
      if (sbd.size() > 0 && sbd[0].idx == n) begin
        de = sbd.pop_front();
        chk($sformatf("d_byte%0d", de.idx), if_d.pixdata, de.val);
      end
      tick();
      n++;
    end
    chk("d_line_len", n, 1280);
    chk("d_sb_left", sbd.size(), 0);
    rst_d = 1'b1;
    if_d.enable = 1'b0;
    #1;
    chk("d_rst_busy", if_d.busy, 0);
    tick();

    // Small instance: bars, then ramp, then checker for two frames.
    push_frame(0, 0);
    push_frame(1, 1);
    push_frame(2, 2);
    push_frame(2, 3);
    mon_en = 1'b1;
    if_s.pattern_sel = 2'd0;
    if_s.enable = 1'b1;
    wait_hi("s_vs_rise", 0, 10, c);
    n = 0;
    while (if_s.vsync && n < 100) begin tick(); n++; end
    chk("s_vs_len", n, 40);
    wait_hi("s_href_rise", 1, 200, c);
    chk("s_href_delay", 40 + c, 120);
    if_s.pattern_sel = 2'd1;   // mid-frame change must not affect this frame
    for (int ln = 0; ln < 4; ln++) begin
      n = 0;
      while (if_s.href && n < 100) begin tick(); n++; end
      chk($sformatf("s_href_hi%0d", ln), n, 32);
      if (ln < 3) begin
        n = 0;
        while (!if_s.href && n < 100) begin tick(); n++; end
        chk($sformatf("s_href_lo%0d", ln), n, 8);
      end
    end
    wait_hi("s_fd0", 2, 400, c);
    chk("s_fcnt_at_fd0", if_s.frame_cnt, 1);
    tick();
    chk("s_fd_width", if_s.frame_done, 0);
    wait_hi("s_f1_href", 5, 400, c1);
    if_s.pattern_sel = 2'd2;
    wait_hi("s_fd1", 2, 400, c2);
    chk("s_frame_period", 1 + c1 + c2, 320);

    // Reset in the middle of frame 3's active region.
    wait_hi("s_f3_href", 6, 1000, c);
    repeat (50) tick();
    chk("s_pre_rst_href", if_s.href, 1);
    chk("s_pre_rst_busy", if_s.busy, 1);
    mon_en = 1'b0;
    rst_s = 1'b1;
    if_s.enable = 1'b0;
    #1;
    chk("mid_rst_vsync",      if_s.vsync, 0);
    chk("mid_rst_href",       if_s.href, 0);
    chk("mid_rst_pixdata",    if_s.pixdata, 0);
    chk("mid_rst_frame_cnt",  if_s.frame_cnt, 0);
    chk("mid_rst_frame_done", if_s.frame_done, 0);
    chk("mid_rst_busy",       if_s.busy, 0);
    sbq.delete();
    tick(); tick();
    rst_s = 1'b0;
    tick(); tick();
    chk("post_rst_busy",  if_s.busy, 0);
    chk("post_rst_vsync", if_s.vsync, 0);

    // Enable dropped during frame 2: that frame completes, then the block idles.
    fd_cnt = 0;
    if_s.pattern_sel = 2'd3;
    for (int f = 0; f < 3; f++) push_frame(3, f);
    mon_en = 1'b1;
    if_s.enable = 1'b1;
    wait_hi("t5_f2_href", 7, 1200, c);
    if_s.enable = 1'b0;
    wait_hi("t5_fd", 2, 400, c);
    chk("t5_fcnt", if_s.frame_cnt, 3);
    chk("t5_busy_at_fd", if_s.busy, 1);
    tick();
    chk("t5_busy_fall", if_s.busy, 0);
    chk("t5_fd_clear", if_s.frame_done, 0);
    vs_seen = 1'b0;
    repeat (400) begin
      tick();
      if (if_s.vsync) vs_seen = 1'b1;
    end
    chk("t5_vsync_quiet", vs_seen, 0);
    chk("t5_fd_count", fd_cnt, 3);
    chk("t5_sb_left", sbq.size(), 0);
    chk("t5_fcnt_hold", if_s.frame_cnt, 3);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
